// File: rtl/sequencer_pkg.sv
// Shared types and constants for the instruction sequencer: FSM state encoding,
// instruction field layout and error codes.
package sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_RETIRE = 3'd3,
    S_ERROR  = 3'd4
  } seq_state_t;

  localparam logic [3:0] FSM_START_IDLE = 4'b1111;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned SEL_HI  = 19;
  localparam int unsigned SEL_LO  = 16;
  localparam int unsigned OP_HI   = 15;
  localparam int unsigned OP_LO   = 12;
  localparam int unsigned P1_HI   = 11;
  localparam int unsigned P1_LO   = 6;
  localparam int unsigned P2_HI   = 5;
  localparam int unsigned P2_LO   = 0;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL_SEL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT     = 2'b10;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] opcode;
    logic [5:0] param1;
    logic [5:0] param2;
  } instr_t;

  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] d);
    instr_t r;
    r.sel    = d[SEL_HI:SEL_LO];
    r.opcode = d[OP_HI:OP_LO];
    r.param1 = d[P1_HI:P1_LO];
    r.param2 = d[P2_HI:P2_LO];
    return r;
  endfunction

endpackage

// File: rtl/seq_fifo.sv
// Synchronous instruction FIFO with async active-low reset. Exposes the head
// and the entry behind it so a retiring head can hand over without a bubble.
module seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 20
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           next_head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fsm_sequencer.sv
// Serialising front-end for the datapath FSMs sharing the register bus.
// Optional watchdog on WAIT enabled by defining SEQ_TIMEOUT_EN.
module fsm_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NUM_FSM = 4,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [3:0]         fsm_start,
  output logic [3:0]         opcode,
  output logic [5:0]         param1,
  output logic [5:0]         param2,
  input  logic [NUM_FSM-1:0] fsm_done,
  output logic               busy,
  output logic               instr_retired,
  output logic               error,
  output logic [1:0]         error_code,
  input  logic               error_clear
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [3:0]         sel_q;
  logic               sel_ok_q;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic [INSTR_W-1:0] fifo_next;
  logic [CNT_W-1:0]   fifo_count;
  instr_t             latch_instr;
  logic               latch;
  logic               latch_ok;
  logic               done_sel;
  logic               timeout_hit;
  logic [1:0]         code_d;
  logic [3:0]         start_d;

  assign instr_ready = !fifo_full;
  assign fifo_push   = instr_valid && !fifo_full;

  seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .din       (instr_data),
    .head      (fifo_head),
    .next_head (fifo_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    done_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_FSM; i++) begin
      if (32'(sel_q) == i) done_sel = fsm_done[i];
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (state_q == S_WAIT && state_d == S_WAIT) begin
      wdog_q <= wdog_q + WD_W'(1);
    end else begin
      wdog_q <= '0;
    end
  end

  // Counter holds cycles already spent in WAIT, so this fires in the
  // TIMEOUT-th WAIT cycle; a done in that same cycle still retires.
  assign timeout_hit = (state_q == S_WAIT) && (32'(wdog_q) == TIMEOUT - 1);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    latch       = 1'b0;
    latch_instr = unpack_instr(fifo_head);
    code_d      = error_code;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_ISSUE;
          latch   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!sel_ok_q) begin
          state_d  = S_ERROR;
          code_d   = ERR_ILLEGAL_SEL;
          fifo_pop = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (done_sel) begin
          state_d = S_RETIRE;
        end else if (timeout_hit) begin
          state_d  = S_ERROR;
          code_d   = ERR_TIMEOUT;
          fifo_pop = 1'b1;
        end
      end
      S_RETIRE: begin
        // Head is still in the FIFO here, so a follow-on entry is the one behind it.
        fifo_pop = 1'b1;
        if (fifo_count > CNT_W'(1)) begin
          state_d     = S_ISSUE;
          latch       = 1'b1;
          latch_instr = unpack_instr(fifo_next);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERROR: begin
        if (error_clear) begin
          state_d = S_IDLE;
          code_d  = ERR_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    latch_ok = (32'(latch_instr.sel) < NUM_FSM);
    start_d  = (latch && latch_ok) ? latch_instr.sel : FSM_START_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      sel_ok_q      <= 1'b0;
      fsm_start     <= FSM_START_IDLE;
      opcode        <= '0;
      param1        <= '0;
      param2        <= '0;
      busy          <= 1'b0;
      instr_retired <= 1'b0;
      error         <= 1'b0;
      error_code    <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      fsm_start <= start_d;
      if (latch) begin
        sel_q    <= latch_instr.sel;
        sel_ok_q <= latch_ok;
        opcode   <= latch_instr.opcode;
        param1   <= latch_instr.param1;
        param2   <= latch_instr.param2;
      end
      busy          <= (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_RETIRE);
      instr_retired <= (state_d == S_RETIRE);
      error         <= (state_d == S_ERROR);
      error_code    <= code_d;
    end
  end

endmodule
